pe_mac_ws: RTL and testbench
============================

Name: pe_mac_ws

Overview:
Weight-stationary INT MAC processing element. It is the parametrised successor to the pass-through PE stub and performs a real multiply-accumulate. Each PE holds a double-buffered stationary weight and forwards activations east with 1-cycle latency. It adds its product to the partial sum arriving from the north over a 2-stage pipeline. It is tiled as the sa_engine systolic array cell, with weights daisy-chained down each column.

Parameters:
ELEM_BITS, 8, activation/weight width.
ACC_BITS, 32, partial-sum width; must be >= 2*ELEM_BITS+1 (elaboration assertion).

Ports:
clk  in  1  clock.
rst  in  1  asynchronous, active-high reset.
cfg_signed  in  1  1 = signed operands and psum; 0 = unsigned. Sampled per beat.
cfg_sat  in  1  1 = saturating add; 0 = wrap. Sampled per beat.
w_load  in  1  capture w_in into the shadow weight.
w_in  in  ELEM_BITS  weight from the north PE or the loader.
w_out  out  ELEM_BITS  shadow weight, feeding the south PE chain.
w_swap  in  1  copy shadow weight to active weight.
a_in  in  ELEM_BITS  activation from the west.
a_vld_in  in  1  a_in/ps_in valid.
a_out  out  ELEM_BITS  activation to the east.
a_vld_out  out  1  forwarded valid.
ps_in  in  ACC_BITS  partial sum from the north, aligned with a_vld_in.
ps_out  out  ACC_BITS  partial sum to the south.
ps_vld_out  out  1  ps_out valid.
clr_ovf  in  1  clear sticky overflow.
ovf_sticky  out  1  overflow seen since the last clear.

Behaviour:
- Reset (async assert, sync release): all registers are 0, including w_shadow, w_active, a_out, a_vld_out, the pipeline, ps_out, ps_vld_out and ovf_sticky. Reset mid-operation discards in-flight beats with no residual valid.
- Weight chain:
  - On w_load: w_shadow <= w_in. w_out = w_shadow, so chain latency is 1 cycle per PE.
  - On w_swap: w_active <= w_shadow.
  - w_load and w_swap in the same cycle: w_active takes the OLD shadow and the shadow takes w_in.
  - A swap takes effect the cycle after it is asserted. A beat presented in the swap cycle uses the old w_active.
- Activation forwarding: every cycle, a_out <= a_in and a_vld_out <= a_vld_in. This is unconditional and independent of the weights.
- Stage 1 (when a_vld_in=1):
  - prod1 <= a_in * w_active, 2*ELEM_BITS wide: signed x signed if cfg_signed, else unsigned x unsigned.
  - ps1 <= ps_in; sgn1 <= cfg_signed; sat1 <= cfg_sat; v1 <= 1.
  - When a_vld_in=0: v1 <= 0 and the data registers hold.
- Stage 2 (when v1=1):
  - sum = ps1 + ext(prod1). ext is sign-extension if sgn1, else zero-extension. Compute at ACC_BITS+1 bits.
  - Signed overflow: operands have equal sign and the result sign differs. Unsigned overflow: carry out of ACC_BITS.
  - If overflow and sat1: clamp to 2^(ACC_BITS-1)-1 or -2^(ACC_BITS-1) (signed, per direction), or 2^ACC_BITS-1 (unsigned). Otherwise truncate (wrap).
  - ps_out <= result; ps_vld_out <= 1.
  - When v1=0: ps_vld_out <= 0 and ps_out holds its last value.
- Latency: ps_in/a_in to ps_out is 2 cycles. Full throughput of 1 beat/cycle; back-to-back beats and arbitrary bubbles are allowed.
- Mode bits travel with their beat. Changing cfg_* between consecutive beats is legal and affects only the later beat.
- ovf_sticky is set on any stage-2 overflow, in saturating or wrap mode. clr_ovf clears it. If set and clear occur in the same cycle, set wins (ovf_sticky=1).
- No backpressure. The array controller guarantees alignment of a_vld_in and ps_in.

Test Plan:
- Reset: assert rst mid-stream with v1=1 -> all outputs 0 immediately; no ps_vld_out pulse after release.
- Basic MAC (signed): w_load w_in=-3, then w_swap; a_in=5, ps_in=100, a_vld_in=1 at cycle T -> a_out=5 and a_vld_out=1 at T+1; ps_out=85 and ps_vld_out=1 at T+2. w_out=-3 one cycle after w_load.
- Swap collision: w_active=2, shadow=7; beat a=10, ps=0 in the same cycle as w_swap -> ps_out=20. The next beat a=10 -> ps_out=70.
- Saturation/wrap: w=127, a=127, ps_in=0x7FFFFF00, signed:
  - cfg_sat=1 -> ps_out=0x7FFFFFFF, ovf_sticky=1.
  - cfg_sat=0 -> ps_out=0x80003E01, ovf_sticky=1.
  - clr_ovf coincident with a new overflow -> ovf_sticky stays 1.
- Mode per beat: w=0xFF, back-to-back beats a=0xFF ps=0, first cfg_signed=0 then cfg_signed=1 -> ps_out=65025, then 1.
- Bubbles: valid pattern 1,0,1,1 -> ps_vld_out mirrors it 2 cycles later; ps_out holds during the bubble.

Source files
------------

// File: rtl/pe_mac_ws.sv
// Weight-stationary INT MAC cell: activations forward east in 1 cycle, psum north->south in 2 cycles.
// No backpressure: one beat per cycle, bubbles marked by a_vld_in=0; weights double-buffered (shadow/active).
module pe_mac_ws #(
  parameter int ELEM_BITS = 8,
  parameter int ACC_BITS  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_signed,
  input  logic                 cfg_sat,
  input  logic                 w_load,
  input  logic [ELEM_BITS-1:0] w_in,
  output logic [ELEM_BITS-1:0] w_out,
  input  logic                 w_swap,
  input  logic [ELEM_BITS-1:0] a_in,
  input  logic                 a_vld_in,
  output logic [ELEM_BITS-1:0] a_out,
  output logic                 a_vld_out,
  input  logic [ACC_BITS-1:0]  ps_in,
  output logic [ACC_BITS-1:0]  ps_out,
  output logic                 ps_vld_out,
  input  logic                 clr_ovf,
  output logic                 ovf_sticky
);

  localparam int PW = 2 * ELEM_BITS;

  generate
    if (ACC_BITS < 2 * ELEM_BITS + 1) begin : g_bad_acc_bits
      $error("pe_mac_ws: ACC_BITS must be >= 2*ELEM_BITS+1");
    end
  endgenerate

  logic [ELEM_BITS-1:0] r_w_shadow;
  logic [ELEM_BITS-1:0] r_w_active;
  logic [ELEM_BITS-1:0] r_a;
  logic                 r_a_vld;

  logic [PW-1:0]        r_prod1;
  logic [ACC_BITS-1:0]  r_ps1;
  logic                 r_sgn1;
  logic                 r_sat1;
  logic                 r_v1;

  logic [ACC_BITS-1:0]  r_ps_out;
  logic                 r_ps_vld;
  logic                 r_ovf;

  // Operands are extended to the product width first, so one unsigned multiply
  // gives the correct low PW bits for both signed and unsigned modes.
  logic [PW-1:0]        w_a_ext;
  logic [PW-1:0]        w_wt_ext;
  logic [PW-1:0]        w_prod;

  assign w_a_ext  = cfg_signed ? {{ELEM_BITS{a_in[ELEM_BITS-1]}}, a_in}
                               : {{ELEM_BITS{1'b0}}, a_in};
  assign w_wt_ext = cfg_signed ? {{ELEM_BITS{r_w_active[ELEM_BITS-1]}}, r_w_active}
                               : {{ELEM_BITS{1'b0}}, r_w_active};
  assign w_prod   = w_a_ext * w_wt_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_w_shadow <= '0;
      r_w_active <= '0;
    end else begin
      if (w_load) r_w_shadow <= w_in;
      if (w_swap) r_w_active <= r_w_shadow;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_a_vld <= 1'b0;
    end else begin
      r_a     <= a_in;
      r_a_vld <= a_vld_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod1 <= '0;
      r_ps1   <= '0;
      r_sgn1  <= 1'b0;
      r_sat1  <= 1'b0;
      r_v1    <= 1'b0;
    end else begin
      r_v1 <= a_vld_in;
      if (a_vld_in) begin
        r_prod1 <= w_prod;
        r_ps1   <= ps_in;
        r_sgn1  <= cfg_signed;
        r_sat1  <= cfg_sat;
      end
    end
  end

  logic [ACC_BITS-1:0] w_ext;
  logic [ACC_BITS:0]   w_sum;
  logic                w_ovf_s;
  logic                w_ovf_u;
  logic                w_ovf;
  logic [ACC_BITS-1:0] w_res;

  assign w_ext   = r_sgn1 ? {{(ACC_BITS-PW){r_prod1[PW-1]}}, r_prod1}
                          : {{(ACC_BITS-PW){1'b0}}, r_prod1};
  assign w_sum   = {1'b0, r_ps1} + {1'b0, w_ext};
  assign w_ovf_s = (r_ps1[ACC_BITS-1] == w_ext[ACC_BITS-1]) &&
                   (w_sum[ACC_BITS-1] != r_ps1[ACC_BITS-1]);
  assign w_ovf_u = w_sum[ACC_BITS];
  assign w_ovf   = r_sgn1 ? w_ovf_s : w_ovf_u;

  // Signed overflow direction follows the (shared) operand sign.
  always_comb begin
    w_res = w_sum[ACC_BITS-1:0];
    if (w_ovf && r_sat1) begin
      if (!r_sgn1)
        w_res = {ACC_BITS{1'b1}};
      else if (r_ps1[ACC_BITS-1])
        w_res = {1'b1, {(ACC_BITS-1){1'b0}}};
      else
        w_res = {1'b0, {(ACC_BITS-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ps_out <= '0;
      r_ps_vld <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_ps_vld <= r_v1;
      if (r_v1) r_ps_out <= w_res;
      if (r_v1 && w_ovf)
        r_ovf <= 1'b1;
      else if (clr_ovf)
        r_ovf <= 1'b0;
    end
  end

  assign w_out      = r_w_shadow;
  assign a_out      = r_a;
  assign a_vld_out  = r_a_vld;
  assign ps_out     = r_ps_out;
  assign ps_vld_out = r_ps_vld;
  assign ovf_sticky = r_ovf;

endmodule

// File: tb/tb_pe_mac_ws.sv
// Bench for pe_mac_ws: directed vector table, mid-stream reset, then random beats vs. an arithmetic model.
module tb_pe_mac_ws;

  localparam int EB = 8;
  localparam int AB = 32;
  localparam int NV = 29;
  localparam longint SMAX = 64'sh7FFF_FFFF;
  localparam longint SMIN = -64'sh8000_0000;
  localparam longint UMAX = 64'sh0_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_signed = 1'b0;
  logic          cfg_sat = 1'b0;
  logic          w_load = 1'b0;
  logic [EB-1:0] w_in = '0;
  logic [EB-1:0] w_out;
  logic          w_swap = 1'b0;
  logic [EB-1:0] a_in = '0;
  logic          a_vld_in = 1'b0;
  logic [EB-1:0] a_out;
  logic          a_vld_out;
  logic [AB-1:0] ps_in = '0;
  logic [AB-1:0] ps_out;
  logic          ps_vld_out;
  logic          clr_ovf = 1'b0;
  logic          ovf_sticky;

  always #5 clk = ~clk;

  pe_mac_ws #(.ELEM_BITS(EB), .ACC_BITS(AB)) dut (
    .clk(clk), .rst(rst), .cfg_signed(cfg_signed), .cfg_sat(cfg_sat),
    .w_load(w_load), .w_in(w_in), .w_out(w_out), .w_swap(w_swap),
    .a_in(a_in), .a_vld_in(a_vld_in), .a_out(a_out), .a_vld_out(a_vld_out),
    .ps_in(ps_in), .ps_out(ps_out), .ps_vld_out(ps_vld_out),
    .clr_ovf(clr_ovf), .ovf_sticky(ovf_sticky)
  );

  typedef struct packed {
    logic          wl;
    logic [EB-1:0] wi;
    logic          ws;
    logic [EB-1:0] a;
    logic          av;
    logic [AB-1:0] ps;
    logic          sg;
    logic          st;
    logic          cl;
    logic [EB-1:0] e_a;
    logic          e_av;
    logic [AB-1:0] e_ps;
    logic          e_pv;
    logic          e_ov;
    logic [EB-1:0] e_wo;
  } vec_t;

  vec_t tbl [0:NV-1];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input int wl, input int wi, input int ws, input int a, input int av,
                              input int ps, input int sg, input int st, input int cl, input int ea,
                              input int eav, input int eps, input int epv, input int eov, input int ewo);
    vec_t v;
    v.wl = wl[0];   v.wi = wi[EB-1:0]; v.ws = ws[0];
    v.a = a[EB-1:0]; v.av = av[0];     v.ps = eps[AB-1:0];
    v.ps = ps[AB-1:0];
    v.sg = sg[0];   v.st = st[0];      v.cl = cl[0];
    v.e_a = ea[EB-1:0]; v.e_av = eav[0]; v.e_ps = eps[AB-1:0];
    v.e_pv = epv[0];    v.e_ov = eov[0]; v.e_wo = ewo[EB-1:0];
    return v;
  endfunction

  // Reference MAC in plain integer arithmetic.
  function automatic void ref_mac(input logic [EB-1:0] a, input logic [EB-1:0] w, input logic [AB-1:0] ps,
                                  input logic sg, input logic st, output logic [AB-1:0] res, output logic ovf);
    longint p, s, sum;
    if (sg) begin
      p = longint'($signed(a)) * longint'($signed(w));
      s = longint'($signed(ps));
    end else begin
      p = longint'(a) * longint'(w);
      s = longint'(ps);
    end
    sum = s + p;
    res = sum[AB-1:0];
    ovf = 1'b0;
    if (sg && sum > SMAX) begin
      ovf = 1'b1;
      if (st) res = 32'h7FFF_FFFF;
    end else if (sg && sum < SMIN) begin
      ovf = 1'b1;
      if (st) res = 32'h8000_0000;
    end else if (!sg && sum > UMAX) begin
      ovf = 1'b1;
      if (st) res = 32'hFFFF_FFFF;
    end
  endfunction

  task automatic chk(input string nm, input int idx, input logic [AB-1:0] act, input logic [AB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string pfx, input int idx, input logic [EB-1:0] ea, input logic eav,
                         input logic [AB-1:0] eps, input logic epv, input logic eov, input logic [EB-1:0] ewo);
    chk({pfx, "_a_out"},      idx, {24'd0, a_out}, {24'd0, ea});
    chk({pfx, "_a_vld_out"},  idx, {31'd0, a_vld_out}, {31'd0, eav});
    chk({pfx, "_ps_out"},     idx, ps_out, eps);
    chk({pfx, "_ps_vld_out"}, idx, {31'd0, ps_vld_out}, {31'd0, epv});
    chk({pfx, "_ovf_sticky"}, idx, {31'd0, ovf_sticky}, {31'd0, eov});
    chk({pfx, "_w_out"},      idx, {24'd0, w_out}, {24'd0, ewo});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    w_load = 1'b0; w_in = '0; w_swap = 1'b0;
    a_in = '0; a_vld_in = 1'b0; ps_in = '0; clr_ovf = 1'b0;
  endtask

  logic [EB-1:0] m_shadow, m_active;
  logic          m_bvld, m_bovf, m_ovf, b_ovf;
  logic [AB-1:0] m_bres, m_ps, b_res;
  logic          e_pv;
  logic [EB-1:0] e_a;
  logic          e_av;

  initial begin
    // Directed sequence: one row per clock, expectations observed just after that edge.
    tbl[0]  = mk(1, 'hFD, 0, 0,    0, 0,            1, 0, 0, 0,    0, 0,            0, 0, 'hFD);
    tbl[1]  = mk(0, 0,    1, 0,    0, 0,            1, 0, 0, 0,    0, 0,            0, 0, 'hFD);
    tbl[2]  = mk(0, 0,    0, 5,    1, 100,          1, 0, 0, 5,    1, 0,            0, 0, 'hFD);
    tbl[3]  = mk(0, 0,    0, 0,    0, 0,            1, 0, 0, 0,    0, 85,           1, 0, 'hFD);
    tbl[4]  = mk(1, 2,    0, 0,    0, 0,            1, 0, 0, 0,    0, 85,           0, 0, 2);
    tbl[5]  = mk(0, 0,    1, 0,    0, 0,            1, 0, 0, 0,    0, 85,           0, 0, 2);
    tbl[6]  = mk(1, 7,    0, 0,    0, 0,            1, 0, 0, 0,    0, 85,           0, 0, 7);
    tbl[7]  = mk(0, 0,    1, 10,   1, 0,            1, 0, 0, 10,   1, 85,           0, 0, 7);
    tbl[8]  = mk(0, 0,    0, 10,   1, 0,            1, 0, 0, 10,   1, 20,           1, 0, 7);
    tbl[9]  = mk(0, 0,    0, 0,    0, 0,            1, 0, 0, 0,    0, 70,           1, 0, 7);
    tbl[10] = mk(1, 'h7F, 0, 0,    0, 0,            1, 0, 0, 0,    0, 70,           0, 0, 'h7F);
    tbl[11] = mk(0, 0,    1, 0,    0, 0,            1, 0, 0, 0,    0, 70,           0, 0, 'h7F);
    tbl[12] = mk(0, 0,    0, 'h7F, 1, 32'h7FFFFF00, 1, 1, 0, 'h7F, 1, 70,           0, 0, 'h7F);
    tbl[13] = mk(0, 0,    0, 'h7F, 1, 32'h7FFFFF00, 1, 0, 0, 'h7F, 1, 32'h7FFFFFFF, 1, 1, 'h7F);
    tbl[14] = mk(0, 0,    0, 0,    0, 0,            1, 0, 0, 0,    0, 32'h80003E01, 1, 1, 'h7F);
    tbl[15] = mk(0, 0,    0, 0,    0, 0,            1, 0, 1, 0,    0, 32'h80003E01, 0, 0, 'h7F);
    tbl[16] = mk(0, 0,    0, 'h7F, 1, 32'h7FFFFF00, 1, 0, 0, 'h7F, 1, 32'h80003E01, 0, 0, 'h7F);
    tbl[17] = mk(0, 0,    0, 0,    0, 0,            1, 0, 1, 0,    0, 32'h80003E01, 1, 1, 'h7F);
    tbl[18] = mk(1, 'hFF, 0, 0,    0, 0,            1, 0, 0, 0,    0, 32'h80003E01, 0, 1, 'hFF);
    tbl[19] = mk(0, 0,    1, 0,    0, 0,            1, 0, 1, 0,    0, 32'h80003E01, 0, 0, 'hFF);
    tbl[20] = mk(0, 0,    0, 'hFF, 1, 0,            0, 0, 0, 'hFF, 1, 32'h80003E01, 0, 0, 'hFF);
    tbl[21] = mk(0, 0,    0, 'hFF, 1, 0,            1, 0, 0, 'hFF, 1, 65025,        1, 0, 'hFF);
    tbl[22] = mk(0, 0,    0, 0,    0, 0,            1, 0, 0, 0,    0, 1,            1, 0, 'hFF);
    tbl[23] = mk(0, 0,    0, 2,    1, 10,           1, 0, 0, 2,    1, 1,            0, 0, 'hFF);
    tbl[24] = mk(0, 0,    0, 0,    0, 0,            1, 0, 0, 0,    0, 8,            1, 0, 'hFF);
    tbl[25] = mk(0, 0,    0, 3,    1, 10,           1, 0, 0, 3,    1, 8,            0, 0, 'hFF);
    tbl[26] = mk(0, 0,    0, 4,    1, 0,            1, 0, 0, 4,    1, 7,            1, 0, 'hFF);
    tbl[27] = mk(0, 0,    0, 0,    0, 0,            1, 0, 0, 0,    0, 32'hFFFFFFFC, 1, 0, 'hFF);
    tbl[28] = mk(0, 0,    0, 0,    0, 0,            1, 0, 0, 0,    0, 32'hFFFFFFFC, 0, 0, 'hFF);

    idle_inputs();
    rst = 1'b1;
    #1;
    chk_all("reset", 0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    step();
    step();
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      w_load = tbl[i].wl; w_in = tbl[i].wi; w_swap = tbl[i].ws;
      a_in = tbl[i].a; a_vld_in = tbl[i].av; ps_in = tbl[i].ps;
      cfg_signed = tbl[i].sg; cfg_sat = tbl[i].st; clr_ovf = tbl[i].cl;
      step();
      chk_all("vec", i, tbl[i].e_a, tbl[i].e_av, tbl[i].e_ps, tbl[i].e_pv, tbl[i].e_ov, tbl[i].e_wo);
    end

    // Mid-stream reset with both pipeline stages holding valid beats.
    idle_inputs();
    w_load = 1'b1; w_in = 8'h7F;
    step();
    idle_inputs();
    w_swap = 1'b1;
    step();
    idle_inputs();
    cfg_signed = 1'b1; cfg_sat = 1'b1;
    a_in = 8'h7F; a_vld_in = 1'b1; ps_in = 32'h7FFF_FF00;
    step();
    step();
    chk("pre_rst_ps_out", 0, ps_out, 32'h7FFF_FFFF);
    chk("pre_rst_ps_vld", 0, {31'd0, ps_vld_out}, 32'd1);
    chk("pre_rst_ovf", 0, {31'd0, ovf_sticky}, 32'd1);
    idle_inputs();
    rst = 1'b1;
    #1;
    chk_all("midrst", 0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_ps_vld", i, {31'd0, ps_vld_out}, 32'd0);
      chk("post_rst_ps_out", i, ps_out, 32'd0);
      chk("post_rst_a_vld", i, {31'd0, a_vld_out}, 32'd0);
    end

    // Random beats against the arithmetic model; state is all-zero after the reset above.
    m_shadow = '0; m_active = '0; m_bvld = 1'b0; m_bovf = 1'b0; m_bres = '0;
    m_ps = '0; m_ovf = 1'b0;
    for (int c = 0; c < 800; c++) begin
      w_load     = ($urandom_range(0, 3) == 0);
      w_in       = 8'($urandom);
      w_swap     = ($urandom_range(0, 3) == 0);
      a_in       = 8'($urandom);
      a_vld_in   = ($urandom_range(0, 9) < 7);
      cfg_signed = 1'($urandom);
      cfg_sat    = 1'($urandom);
      clr_ovf    = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0: ps_in = 32'($urandom);
        1: ps_in = 32'h7FFF_FF00 + 32'($urandom_range(0, 511));
        2: ps_in = 32'h8000_0000 + 32'($urandom_range(0, 511));
        default: ps_in = 32'hFFFF_FE00 + 32'($urandom_range(0, 511));
      endcase

      b_res = '0;
      b_ovf = 1'b0;
      if (a_vld_in) ref_mac(a_in, m_active, ps_in, cfg_signed, cfg_sat, b_res, b_ovf);
      e_pv  = m_bvld;
      if (m_bvld) m_ps = m_bres;
      m_ovf = (m_bvld && m_bovf) || (m_ovf && !clr_ovf);
      m_bvld = a_vld_in; m_bres = b_res; m_bovf = b_ovf;
      if (w_swap) m_active = m_shadow;
      if (w_load) m_shadow = w_in;
      e_a  = a_in;
      e_av = a_vld_in;

      step();
      chk_all("rnd", c, e_a, e_av, m_ps, e_pv, m_ovf, m_shadow);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
